// File: rtl/dither_result_writer.sv
// dither_result_writer
// Packs a raster stream of 1-bit dithered pixels into 32-bit words, LSB-first
// (bit 0 = leftmost pixel), and writes them to consecutive word addresses
// starting at base_addr. Every row begins in a fresh word and the unused
// upper bits of a row's last word are zero, so each row occupies exactly
// ceil(img_w/32) words. Each write is held on the memory port until mem_ack.
module dither_result_writer #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [DIM_W-1:0]  img_h,
    input  logic              pix_valid,
    input  logic              pix_data,
    output logic              pix_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [DIM_W-1:0]  DIM_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_reg;
    logic [DIM_W-1:0]  w_reg;      // latched image width
    logic [DIM_W-1:0]  h_reg;      // latched image height
    logic [DIM_W-1:0]  col_reg;    // pixels accepted so far in the current row
    logic [DIM_W-1:0]  row_reg;    // rows fully written so far
    logic [4:0]        bit_reg;    // next free bit in the word being assembled
    logic [31:0]       word_reg;   // word being assembled / held for writing

    logic [31:0]       word_ins;   // word_reg with the incoming pixel dropped in
    logic              xfer;
    logic              last_in_word;
    logic              last_in_row;
    logic              row_end;
    logic              last_row;

    // The word register is presented directly to memory; it is frozen in WRITE.
    assign mem_wdata = word_reg;

    // A pixel moves only on a valid/ready handshake; ready is high only in COLLECT.
    assign xfer = pix_valid & pix_ready;

    // Word-completion conditions, evaluated against the counters before the
    // current transfer is applied.
    assign last_in_word = (bit_reg == 5'd31);
    assign last_in_row  = (col_reg == w_reg - DIM_ONE);

    // In WRITE, the column counter has already passed the last pixel of the row
    // exactly when the held word is the row's final word.
    assign row_end  = (col_reg == w_reg);
    assign last_row = (row_reg == h_reg - DIM_ONE);

    // Per-bit insert of the incoming pixel at position bit_reg.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_ins
            localparam logic [4:0] IDX = 5'(gi);
            assign word_ins[gi] = (bit_reg == IDX) ? pix_data : word_reg[gi];
        end
    endgenerate

    // Frame controller: state, counters, word assembly and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            w_reg     <= '0;
            h_reg     <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
            bit_reg   <= '0;
            word_reg  <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            pix_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        w_reg    <= img_w;
                        h_reg    <= img_h;
                        col_reg  <= '0;
                        row_reg  <= '0;
                        bit_reg  <= '0;
                        word_reg <= '0;
                        mem_addr <= base_addr;
                        busy     <= 1'b1;
                        // An empty frame completes without touching memory.
                        if ((img_w == '0) || (img_h == '0)) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= COLLECT;
                            pix_ready <= 1'b1;
                        end
                    end
                end

                COLLECT: begin
                    if (xfer) begin
                        word_reg <= word_ins;
                        bit_reg  <= bit_reg + 5'd1;
                        col_reg  <= col_reg + DIM_ONE;
                        // Word is full or row is finished: hand it to memory.
                        if (last_in_word || last_in_row) begin
                            state_reg <= WRITE;
                            pix_ready <= 1'b0;
                            mem_we    <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    // Address and data stay put until memory takes the word.
                    if (mem_ack) begin
                        mem_we   <= 1'b0;
                        mem_addr <= mem_addr + ADDR_ONE;
                        word_reg <= '0;
                        bit_reg  <= '0;
                        if (row_end) begin
                            col_reg <= '0;
                            row_reg <= row_reg + DIM_ONE;
                        end
                        if (row_end && last_row) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                        end else begin
                            state_reg <= COLLECT;
                            pix_ready <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // Single-cycle completion pulse, then back to idle.
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                    mem_we    <= 1'b0;
                    pix_ready <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dither_result_writer.sv
// Testbench for dither_result_writer: random pixel streams, random valid gaps,
// variable memory acknowledge latency and stray start pulses, checked against
// a frame-level model that lists the words the frame must produce.
module tb_dither_result_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic [11:0] img_w;
    logic [11:0] img_h;
    logic        pix_valid;
    logic        pix_data;
    logic        pix_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        busy;
    logic        done;

    dither_result_writer #(.ADDR_W(16), .DIM_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .img_w     (img_w),
        .img_h     (img_h),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    bit    pix_q[$];        // pixels still to be offered, raster order
    wr_t   exp_q[$];        // writes the frame must still produce
    int    ack_delay = 0;   // cycles of mem_we before ack; -1 = ack tied high
    int    valid_pct = 100;
    bit    spur_en   = 0;
    int    cur_w     = 0;
    int    m_col     = 0;
    int    m_bit     = 0;
    int    hold      = 0;
    int    done_cnt  = 0;
    int    wr_cnt    = 0;
    bit    prev_we, prev_ack, prev_complete, prev_done;
    logic [15:0] prev_addr;
    logic [31:0] prev_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Frame-level model: ceil(w/32) words per row, LSB-first, zero padded,
    // consecutive addresses wrapping at 16 bits.
    task automatic build_exp(input int w, input int h, input logic [15:0] base);
        logic [15:0] addr;
        logic [31:0] d;
        int          c;
        wr_t         e;
        exp_q.delete();
        addr = base;
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < (w + 31) / 32; k++) begin
                d = '0;
                for (int b = 0; b < 32; b++) begin
                    c = k * 32 + b;
                    if (c < w) d[b] = pix_q[r * w + c];
                end
                e.a = addr;
                e.d = d;
                exp_q.push_back(e);
                addr = addr + 16'd1;
            end
        end
    endtask

    task automatic fill_random(input int n);
        pix_q.delete();
        for (int i = 0; i < n; i++) pix_q.push_back(1'($urandom));
    endtask

    task automatic fill_ones(input int n);
        pix_q.delete();
        for (int i = 0; i < n; i++) pix_q.push_back(1'b1);
    endtask

    // One clock: check the outputs visible this cycle, then drive the inputs
    // for the coming rising edge (pixel source, memory responder, start).
    task automatic tick(input bit st);
        bit  pv, ack, complete, spur;
        wr_t e;
        @(negedge clk);
        if (rst) begin
            chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
            chk("rst_pix_ready", {31'd0, pix_ready}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
            pix_valid = 1'b0;
            mem_ack   = 1'b0;
            start     = 1'b0;
            prev_we = 0; prev_ack = 0; prev_complete = 0; prev_done = 0;
            hold = 0; m_col = 0; m_bit = 0;
            return;
        end
        // write request timing and stability
        if (!prev_we)      chk("we_rise", {31'd0, mem_we}, {31'd0, prev_complete});
        else if (prev_ack) chk("we_fall", {31'd0, mem_we}, 32'd0);
        else begin
            chk("we_hold", {31'd0, mem_we}, 32'd1);
            chk("addr_hold", {16'd0, mem_addr}, {16'd0, prev_addr});
            chk("data_hold", mem_wdata, prev_data);
        end
        if (mem_we) chk("ready_during_write", {31'd0, pix_ready}, 32'd0);
        if (pix_ready || mem_we || done) chk("busy_active", {31'd0, busy}, 32'd1);
        if (done) begin
            done_cnt++;
            chk("done_single", {31'd0, prev_done}, 32'd0);
        end
        if (!busy) begin
            m_col = 0;
            m_bit = 0;
        end
        // memory responder
        if (ack_delay < 0) ack = 1'b1;
        else               ack = mem_we && (hold >= ack_delay);
        mem_ack = ack;
        if (mem_we && ack) begin
            if (exp_q.size() == 0) fail_now("unexpected_write");
            else begin
                e = exp_q.pop_front();
                chk("wr_addr", {16'd0, mem_addr}, {16'd0, e.a});
                chk("wr_data", mem_wdata, e.d);
                $display("write addr=%h data=%h", mem_addr, mem_wdata);
            end
            wr_cnt++;
            m_bit = 0;
            if (m_col == cur_w) m_col = 0;
        end
        hold = (mem_we && !ack) ? hold + 1 : 0;
        // pixel source
        pv = (valid_pct >= 100) || ($urandom_range(99) < valid_pct);
        pix_valid = pv;
        pix_data  = (pix_q.size() > 0) ? pix_q[0] : 1'($urandom);
        complete  = 1'b0;
        if (pv && pix_ready) begin
            if (pix_q.size() == 0) fail_now("extra_pixel");
            else void'(pix_q.pop_front());
            complete = (m_bit == 31) || (m_col == cur_w - 1);
            m_bit++;
            m_col++;
        end
        // stray start pulses with junk configuration while busy
        spur  = spur_en && busy && ($urandom_range(3) == 0);
        start = st | spur;
        if (spur) begin
            img_w     = 12'($urandom);
            img_h     = 12'($urandom);
            base_addr = 16'($urandom);
        end
        prev_we       = mem_we;
        prev_ack      = ack;
        prev_addr     = mem_addr;
        prev_data     = mem_wdata;
        prev_complete = complete;
        prev_done     = done;
    endtask

    // Runs a frame whose pixels are in pix_q and expected writes in exp_q.
    task automatic run_frame(input int w, input int h, input logic [15:0] base,
                             input int vpct, input int adly, input bit spur);
        int  exp_words;
        bit  seen;
        exp_words = exp_q.size();
        valid_pct = vpct;
        ack_delay = adly;
        spur_en   = 1'b0;
        cur_w     = w;
        done_cnt  = 0;
        wr_cnt    = 0;
        img_w     = 12'(w);
        img_h     = 12'(h);
        base_addr = base;
        tick(1'b1);
        spur_en = spur;
        seen = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            tick(1'b0);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("done_timeout");
        spur_en = 1'b0;
        tick(1'b0);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("done_after_done", {31'd0, done}, 32'd0);
        chk("words_written", wr_cnt, exp_words);
        chk("pixels_left", pix_q.size(), 32'd0);
        chk("writes_left", exp_q.size(), 32'd0);
        chk("done_count", done_cnt, 32'd1);
        $display("frame w=%0d h=%0d base=%h valid=%0d%% ackdly=%0d stray=%0d words=%0d",
                 w, h, base, vpct, adly, spur, wr_cnt);
    endtask

    task automatic run_random_frame(input int w, input int h, input logic [15:0] base,
                                    input int vpct, input int adly, input bit spur);
        fill_random(w * h);
        build_exp(w, h, base);
        run_frame(w, h, base, vpct, adly, spur);
    endtask

    task automatic load_req035;
        bit pat[8];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        pix_q.delete();
        for (int i = 0; i < 8; i++) pix_q.push_back(pat[i]);
        build_exp(8, 1, 16'h0100);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; start = 1'b0; base_addr = '0; img_w = '0; img_h = '0;
        pix_valid = 1'b0; pix_data = 1'b0; mem_ack = 1'b0;
        prev_we = 0; prev_ack = 0; prev_complete = 0; prev_done = 0;
        prev_addr = '0; prev_data = '0;

        // reset state
        repeat (3) tick(1'b0);
        #2 rst = 1'b0;
        repeat (2) tick(1'b0);

        // 8x1 frame, ack tied high
        load_req035();
        chk("model_035_cnt", exp_q.size(), 32'd1);
        chk("model_035_addr", {16'd0, exp_q[0].a}, 32'h0000_0100);
        chk("model_035_data", exp_q[0].d, 32'h0000_008D);
        run_frame(8, 1, 16'h0100, 100, -1, 1'b0);

        // 40x2 all ones, immediate ack
        fill_ones(80);
        build_exp(40, 2, 16'h0100);
        chk("model_036_cnt", exp_q.size(), 32'd4);
        chk("model_036_a0", {exp_q[0].a, 16'd0}, 32'h0100_0000);
        chk("model_036_d0", exp_q[0].d, 32'hFFFF_FFFF);
        chk("model_036_a1", {exp_q[1].a, 16'd0}, 32'h0101_0000);
        chk("model_036_d1", exp_q[1].d, 32'h0000_00FF);
        chk("model_036_a3", {exp_q[3].a, 16'd0}, 32'h0103_0000);
        chk("model_036_d3", exp_q[3].d, 32'h0000_00FF);
        run_frame(40, 2, 16'h0100, 100, 0, 1'b0);

        // acknowledge delayed by 3 cycles
        run_random_frame(40, 2, 16'h0200, 100, 3, 1'b0);

        // boundary widths
        run_random_frame(1, 3, 16'h0300, 100, 0, 1'b0);
        run_random_frame(32, 2, 16'h0310, 100, 1, 1'b0);
        run_random_frame(33, 2, 16'h0320, 100, 0, 1'b0);
        run_random_frame(64, 1, 16'hFFFF, 100, 0, 1'b0);

        // empty frames: done in the cycle after start, idle the cycle after
        for (int z = 0; z < 2; z++) begin
            pix_q.delete();
            exp_q.delete();
            cur_w = 8; wr_cnt = 0; done_cnt = 0; ack_delay = 0; valid_pct = 100;
            img_w = (z == 0) ? 12'd8 : 12'd0;
            img_h = (z == 0) ? 12'd0 : 12'd5;
            base_addr = 16'h0400;
            tick(1'b1);
            tick(1'b0);
            chk("zero_done", {31'd0, done}, 32'd1);
            chk("zero_busy", {31'd0, busy}, 32'd1);
            tick(1'b0);
            chk("zero_done_clear", {31'd0, done}, 32'd0);
            chk("zero_busy_clear", {31'd0, busy}, 32'd0);
            repeat (3) tick(1'b0);
            chk("zero_writes", wr_cnt, 32'd0);
            chk("zero_done_count", done_cnt, 32'd1);
            $display("empty frame w=%0d h=%0d done_pulses=%0d", img_w, img_h, done_cnt);
        end

        // gaps in pix_valid plus stray starts
        run_random_frame(37, 3, 16'h0500, 100, 1, 1'b0);
        run_random_frame(37, 3, 16'h0500, 45, 1, 1'b1);

        // randomized frames
        for (int k = 0; k < 6; k++)
            run_random_frame($urandom_range(70, 1), $urandom_range(3, 1),
                             (k == 0) ? 16'hFFFE : 16'($urandom),
                             $urandom_range(100, 30), $urandom_range(3, 0),
                             1'($urandom));

        // reset while a write is pending
        fill_random(80);
        build_exp(40, 2, 16'h0600);
        valid_pct = 100; ack_delay = 6; spur_en = 0; cur_w = 40; wr_cnt = 0;
        img_w = 12'd40; img_h = 12'd2; base_addr = 16'h0600;
        tick(1'b1);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            tick(1'b0);
            if (mem_we) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("wait_mem_we_timeout");
        #2 rst = 1'b1;
        #1;
        chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
        chk("abort_pix_ready", {31'd0, pix_ready}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("abort_mem_wdata", mem_wdata, 32'd0);
        repeat (2) tick(1'b0);
        #2 rst = 1'b0;
        pix_q.delete();
        exp_q.delete();
        wr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            chk("no_write_after_abort", {31'd0, mem_we}, 32'd0);
        end
        chk("abort_write_count", wr_cnt, 32'd0);
        $display("abort during write, idle writes=%0d", wr_cnt);

        load_req035();
        run_frame(8, 1, 16'h0100, 100, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
